// File: rtl/serial_adder.sv
// Bit-serial ripple adder: adds two WIDTH-bit operands LSB-first, one bit per clock.
// Optional macro SERIAL_ADDER_OVF_EN adds a registered two's-complement overflow flag (ovf).
module serial_adder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] res_r;
   logic             carry_r;
   logic [CNT_W-1:0] cnt_r;
   logic             busy_r;
   logic             done_r;
   logic [WIDTH-1:0] s_r;
   logic             cout_r;
`ifdef SERIAL_ADDER_OVF_EN
   logic             ovf_r;
`endif

   logic sum_bit_s;
   logic carry_nxt_s;
   logic last_bit_s;
   logic accept_s;

   // Full-adder slice on the current LSBs and the start-acceptance decode
   always_comb begin
      sum_bit_s   = a_r[0] ^ b_r[0] ^ carry_r;
      carry_nxt_s = (a_r[0] & b_r[0]) | (a_r[0] & carry_r) | (b_r[0] & carry_r);
      last_bit_s  = (cnt_r == CNT_LAST);
      accept_s    = start && ((state_r == IDLE) || (state_r == DONE));
   end

   // Control FSM, operand shifters and registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         a_r     <= {WIDTH{1'b0}};
         b_r     <= {WIDTH{1'b0}};
         res_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         s_r     <= {WIDTH{1'b0}};
         cout_r  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
         ovf_r   <= 1'b0;
`endif
      end else if (accept_s) begin
         // DONE accepts a new start exactly like IDLE, giving back-to-back operation
         state_r <= RUN;
         a_r     <= a;
         b_r     <= b;
         res_r   <= {WIDTH{1'b0}};
         carry_r <= cin;
         cnt_r   <= {CNT_W{1'b0}};
         busy_r  <= 1'b1;
         done_r  <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               busy_r <= 1'b0;
               done_r <= 1'b0;
            end
            RUN: begin
               a_r     <= {1'b0, a_r[WIDTH-1:1]};
               b_r     <= {1'b0, b_r[WIDTH-1:1]};
               res_r   <= {sum_bit_s, res_r[WIDTH-1:1]};
               carry_r <= carry_nxt_s;
               if (last_bit_s) begin
                  state_r <= DONE;
                  busy_r  <= 1'b0;
                  done_r  <= 1'b1;
                  s_r     <= {sum_bit_s, res_r[WIDTH-1:1]};
                  cout_r  <= carry_nxt_s;
`ifdef SERIAL_ADDER_OVF_EN
                  // carry_r here is the carry into the MSB
                  ovf_r   <= carry_r ^ carry_nxt_s;
`endif
               end else begin
                  cnt_r <= cnt_r + CNT_ONE;
               end
            end
            DONE: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_r;
   assign done = done_r;
   assign s    = s_r;
   assign cout = cout_r;
`ifdef SERIAL_ADDER_OVF_EN
   assign ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed, random, start-in-RUN,
// mid-run reset and back-to-back scenarios against an arithmetic reference model.
module tb_serial_adder;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [7:0] a;
   logic [7:0] b;
   logic       cin;
   logic       busy;
   logic       done;
   logic [7:0] s;
   logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
   logic       ovf;
`endif

   int errors = 0;
   int checks = 0;

   serial_adder #(.WIDTH(8)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
      .busy (busy),
      .done (done),
      .s    (s),
      .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf  (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer addition; ovf is signed overflow of the 8-bit result
   function automatic logic [9:0] ref_add(input logic [7:0] x, input logic [7:0] y, input logic c);
      int unsigned t;
      logic [7:0]  sm;
      logic        co;
      logic        ov;
      t  = 32'(x) + 32'(y) + 32'(c);
      sm = t[7:0];
      co = t[8];
      ov = (x[7] == y[7]) && (sm[7] != x[7]);
      return {ov, co, sm};
   endfunction

   function automatic logic get_ovf();
`ifdef SERIAL_ADDER_OVF_EN
      return ovf;
`else
      return 1'b0;
`endif
   endfunction

   // Launch one addition and observe 20 cycles after the accepting edge
   task automatic run_op(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                         output int done_cyc, output int busy_cyc, output int pulses,
                         output logic stable, output logic [7:0] os, output logic oc,
                         output logic oo);
      logic [7:0] prev;
      @(negedge clk);
      start = 1'b1; a = ia; b = ib; cin = ic;
      prev = s;
      @(posedge clk);
      done_cyc = 0; busy_cyc = 0; pulses = 0; stable = 1'b1;
      os = 8'h00; oc = 1'b0; oo = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0; a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
         end
         if (busy) busy_cyc++;
         if (done) begin
            pulses++;
            if (done_cyc == 0) begin
               done_cyc = k; os = s; oc = cout; oo = get_ovf();
            end
         end else if (done_cyc == 0 && s !== prev) begin
            stable = 1'b0;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; start = 1'b0; a = 8'h00; b = 8'h00; cin = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL reset_s got %h want 00", s); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %b want 0", cout); end
`ifdef SERIAL_ADDER_OVF_EN
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
`endif
      rst_n = 1'b1;
   endtask

   task automatic test_directed();
      logic [7:0] va [3] = '{8'h0F, 8'hFF, 8'h7F};
      logic [7:0] vb [3] = '{8'h01, 8'h01, 8'h00};
      logic       vc [3] = '{1'b0, 1'b0, 1'b1};
      int dc, bc, pc;
      logic st, oc, oo;
      logic [7:0] os;
      logic [9:0] exp;
      for (int i = 0; i < 3; i++) begin
         exp = ref_add(va[i], vb[i], vc[i]);
         run_op(va[i], vb[i], vc[i], dc, bc, pc, st, os, oc, oo);
         checks++; if (dc !== 9) begin errors++; $display("FAIL dir%0d_latency got %0d want 9", i, dc); end
         checks++; if (bc !== 8) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want 8", i, bc); end
         checks++; if (pc !== 1) begin errors++; $display("FAIL dir%0d_done_pulses got %0d want 1", i, pc); end
         checks++; if (st !== 1'b1) begin errors++; $display("FAIL dir%0d_s_stable got %b want 1", i, st); end
         checks++; if (os !== exp[7:0]) begin errors++; $display("FAIL dir%0d_s got %h want %h", i, os, exp[7:0]); end
         checks++; if (oc !== exp[8]) begin errors++; $display("FAIL dir%0d_cout got %b want %b", i, oc, exp[8]); end
`ifdef SERIAL_ADDER_OVF_EN
         checks++; if (oo !== exp[9]) begin errors++; $display("FAIL dir%0d_ovf got %b want %b", i, oo, exp[9]); end
`endif
      end
   endtask

   task automatic test_random();
      int dc, bc, pc;
      logic st, oc, oo, rc;
      logic [7:0] os, ra, rb;
      logic [9:0] exp;
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         exp = ref_add(ra, rb, rc);
         run_op(ra, rb, rc, dc, bc, pc, st, os, oc, oo);
         checks++;
         if (dc !== 9 || pc !== 1 || st !== 1'b1 || os !== exp[7:0] || oc !== exp[8]
`ifdef SERIAL_ADDER_OVF_EN
             || oo !== exp[9]
`endif
            ) begin
            errors++;
            $display("FAIL rand%0d %h+%h+%b got s=%h c=%b o=%b lat=%0d pulses=%0d stable=%b want s=%h c=%b o=%b lat=9",
                     i, ra, rb, rc, os, oc, oo, dc, pc, st, exp[7:0], exp[8], exp[9]);
         end
      end
   endtask

   task automatic test_start_during_run();
      int dc, pc, bc;
      logic [7:0] os;
      @(negedge clk);
      start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
      @(posedge clk);
      dc = 0; pc = 0; bc = 0; os = 8'h00;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (k == 3) begin start = 1'b1; a = 8'h55; b = 8'h55; end
         if (k == 4) start = 1'b0;
         if (busy) bc++;
         if (done) begin
            pc++;
            if (dc == 0) begin dc = k; os = s; end
         end
      end
      checks++; if (os !== 8'h02) begin errors++; $display("FAIL run_start_s got %h want 02", os); end
      checks++; if (pc !== 1) begin errors++; $display("FAIL run_start_pulses got %0d want 1", pc); end
      checks++; if (dc !== 9) begin errors++; $display("FAIL run_start_latency got %0d want 9", dc); end
      checks++; if (bc !== 8) begin errors++; $display("FAIL run_start_busy got %0d want 8", bc); end
   endtask

   task automatic test_reset_mid_run();
      int pc, dc, bc;
      logic st, oc, oo;
      logic [7:0] os;
      @(negedge clk);
      start = 1'b1; a = 8'hA5; b = 8'h3C; cin = 1'b1;
      @(posedge clk);
      pc = 0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         if (k == 1) start = 1'b0;
         if (done) pc++;
      end
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
      checks++; if (s !== 8'h00) begin errors++; $display("FAIL midrst_s got %h want 00", s); end
      checks++; if (cout !== 1'b0) begin errors++; $display("FAIL midrst_cout got %b want 0", cout); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         if (done) pc++;
      end
      checks++; if (pc !== 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", pc); end
      run_op(8'h03, 8'h04, 1'b0, dc, bc, pc, st, os, oc, oo);
      checks++; if (os !== 8'h07) begin errors++; $display("FAIL midrst_next_s got %h want 07", os); end
      checks++; if (dc !== 9) begin errors++; $display("FAIL midrst_next_latency got %0d want 9", dc); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] a1 = 8'hC3, b1 = 8'h5A, a2 = 8'h12, b2 = 8'h34;
      logic [9:0] e1, e2;
      int d1, d2, pc, bc;
      logic [7:0] s1, s2;
      e1 = ref_add(a1, b1, 1'b1);
      e2 = ref_add(a2, b2, 1'b0);
      @(negedge clk);
      start = 1'b1; a = a1; b = b1; cin = 1'b1;
      @(posedge clk);
      d1 = 0; d2 = 0; pc = 0; bc = 0; s1 = 8'h00; s2 = 8'h00;
      for (int k = 1; k <= 24; k++) begin
         @(negedge clk);
         if (busy) bc++;
         if (done) begin
            pc++;
            if (d1 == 0) begin d1 = k; s1 = s; end
            else if (d2 == 0) begin d2 = k; s2 = s; end
         end
         if (k == 1) begin a = a2; b = b2; cin = 1'b0; end
         if (k == 10) start = 1'b0;
      end
      checks++; if (d1 !== 9) begin errors++; $display("FAIL b2b_first_done got %0d want 9", d1); end
      checks++; if (d2 !== 18) begin errors++; $display("FAIL b2b_second_done got %0d want 18", d2); end
      checks++; if (pc !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", pc); end
      checks++; if (bc !== 16) begin errors++; $display("FAIL b2b_busy got %0d want 16", bc); end
      checks++; if (s1 !== e1[7:0]) begin errors++; $display("FAIL b2b_s1 got %h want %h", s1, e1[7:0]); end
      checks++; if (s2 !== e2[7:0]) begin errors++; $display("FAIL b2b_s2 got %h want %h", s2, e2[7:0]); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_start_during_run();
      test_reset_mid_run();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
